// File: rtl/operand_stream_fifo.sv
// Operand staging FIFO: word-wide push side, PACK-word registered show-ahead beat output
// with flush, drain of zero-padded partial beats, and almost-full threshold.
module operand_stream_fifo #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 16384,
  parameter int unsigned PACK     = 2,
  parameter int unsigned AF_LEVEL = DEPTH - 64,
  parameter int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     drain,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic                     wr_overflow,
  output logic [DATA_W*PACK-1:0]   rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [CNT_W-1:0]         count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned BEAT_W = DATA_W * PACK;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  logic              push_c;
  logic              ld_c;
  logic [CNT_W-1:0]  take_c;
  logic [BEAT_W-1:0] beat_c;

  // Status flags decode the registered count only, so a push is never bypassed into a load.
  assign wr_ready    = count < CNT_W'(DEPTH);
  assign full        = count == CNT_W'(DEPTH);
  assign empty       = count == '0;
  assign almost_full = count >= CNT_W'(AF_LEVEL);
  assign push_c      = wr_valid && wr_ready;

  // Load decision and beat assembly; oldest word lands in the MSB slice, unused slices stay 0.
  always_comb begin
    ld_c   = 1'b0;
    take_c = '0;
    beat_c = '0;
    if (!rd_valid || rd_ready) begin
      if (count >= CNT_W'(PACK)) begin
        ld_c   = 1'b1;
        take_c = CNT_W'(PACK);
      end else if (drain && count != '0) begin
        ld_c   = 1'b1;
        take_c = count;
      end
    end
    for (int i = 0; i < int'(PACK); i++) begin
      if (CNT_W'(i) < take_c) begin
        beat_c[(int'(PACK) - 1 - i) * int'(DATA_W) +: DATA_W] = mem[rd_ptr + AW'(i)];
      end
    end
  end

  // Storage array carries no reset; flush leaves its contents in place.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push_c) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      wr_overflow <= 1'b0;
    end else begin
      wr_overflow <= wr_valid && !wr_ready;
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (ld_c) begin
        rd_ptr   <= rd_ptr + AW'(take_c);
        rd_data  <= beat_c;
        rd_valid <= 1'b1;
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
      count <= count + CNT_W'(push_c) - take_c;
    end
  end

endmodule

// File: tb/tb_operand_stream_fifo.sv
// Directed bench for operand_stream_fifo: a PACK=2 and a PACK=4 instance, both DEPTH=16, AF_LEVEL=12.
module tb_operand_stream_fifo;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  logic        a_flush, a_drain, a_wr_valid, a_wr_ready, a_wr_overflow, a_rd_valid, a_rd_ready;
  logic        a_empty, a_full, a_almost_full;
  logic [31:0] a_wr_data;
  logic [63:0] a_rd_data;
  logic [4:0]  a_count;

  logic         b_flush, b_drain, b_wr_valid, b_wr_ready, b_wr_overflow, b_rd_valid, b_rd_ready;
  logic         b_empty, b_full, b_almost_full;
  logic [31:0]  b_wr_data;
  logic [127:0] b_rd_data;
  logic [4:0]   b_count;

  operand_stream_fifo #(.DATA_W(32), .DEPTH(16), .PACK(2), .AF_LEVEL(12), .CNT_W(5)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush), .drain(a_drain),
    .wr_data(a_wr_data), .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_overflow(a_wr_overflow),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_ready(a_rd_ready),
    .count(a_count), .empty(a_empty), .full(a_full), .almost_full(a_almost_full)
  );

  operand_stream_fifo #(.DATA_W(32), .DEPTH(16), .PACK(4), .AF_LEVEL(12), .CNT_W(5)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush), .drain(b_drain),
    .wr_data(b_wr_data), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_overflow(b_wr_overflow),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_ready(b_rd_ready),
    .count(b_count), .empty(b_empty), .full(b_full), .almost_full(b_almost_full)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // After this returns, the current interval is cycle 0 of the next scenario.
  task automatic do_reset();
    a_flush = 0; a_drain = 0; a_wr_valid = 0; a_wr_data = '0; a_rd_ready = 0;
    b_flush = 0; b_drain = 0; b_wr_valid = 0; b_wr_data = '0; b_rd_ready = 0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (a_count !== 5'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", a_count); end
    tests++; if (a_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b exp=1", a_empty); end
    tests++; if (a_full !== 1'b0) begin fails++; $display("FAIL reset_full got=%b exp=0", a_full); end
    tests++; if (a_almost_full !== 1'b0) begin fails++; $display("FAIL reset_af got=%b exp=0", a_almost_full); end
    tests++; if (a_wr_ready !== 1'b1) begin fails++; $display("FAIL reset_wr_ready got=%b exp=1", a_wr_ready); end
    tests++; if (a_wr_overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%b exp=0", a_wr_overflow); end
    tests++; if (a_rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got=%b exp=0", a_rd_valid); end
    tests++; if (a_rd_data !== 64'h0) begin fails++; $display("FAIL reset_rd_data got=%h exp=0", a_rd_data); end
    tests++; if (b_rd_valid !== 1'b0 || b_rd_data !== 128'h0) begin fails++; $display("FAIL reset_b_out got=%b/%h exp=0/0", b_rd_valid, b_rd_data); end
  endtask

  task automatic test_basic();
    do_reset();
    a_rd_ready = 1; a_wr_valid = 1; a_wr_data = 32'h11;
    step();
    a_wr_data = 32'h22;
    tests++; if (a_rd_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_c1 got=%b exp=0", a_rd_valid); end
    step();
    a_wr_data = 32'h33;
    tests++; if (a_rd_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_c2 got=%b exp=0", a_rd_valid); end
    tests++; if (a_count !== 5'd2) begin fails++; $display("FAIL basic_count_c2 got=%0d exp=2", a_count); end
    step();
    a_wr_data = 32'h44;
    tests++; if (a_rd_valid !== 1'b1) begin fails++; $display("FAIL basic_valid_c3 got=%b exp=1", a_rd_valid); end
    tests++; if (a_rd_data !== 64'h00000011_00000022) begin fails++; $display("FAIL basic_beat0 got=%h exp=0000001100000022", a_rd_data); end
    tests++; if (a_count !== 5'd1) begin fails++; $display("FAIL basic_count_c3 got=%0d exp=1", a_count); end
    step();
    a_wr_valid = 0;
    tests++; if (a_rd_valid !== 1'b0 || a_count !== 5'd2) begin fails++; $display("FAIL basic_c4 got=%b/%0d exp=0/2", a_rd_valid, a_count); end
    step();
    tests++; if (a_rd_valid !== 1'b1) begin fails++; $display("FAIL basic_valid_c5 got=%b exp=1", a_rd_valid); end
    tests++; if (a_rd_data !== 64'h00000033_00000044) begin fails++; $display("FAIL basic_beat1 got=%h exp=0000003300000044", a_rd_data); end
    tests++; if (a_empty !== 1'b1) begin fails++; $display("FAIL basic_empty got=%b exp=1", a_empty); end
    step();
    tests++; if (a_rd_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_c6 got=%b exp=0", a_rd_valid); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      a_wr_valid = 1; a_wr_data = 32'(i + 1);
      step();
    end
    tests++; if (a_count !== 5'd16) begin fails++; $display("FAIL full_count got=%0d exp=16", a_count); end
    tests++; if (a_full !== 1'b1 || a_wr_ready !== 1'b0) begin fails++; $display("FAIL full_flags got=%b/%b exp=1/0", a_full, a_wr_ready); end
    tests++; if (a_rd_valid !== 1'b1 || a_rd_data !== 64'h00000001_00000002) begin fails++; $display("FAIL full_stage got=%b/%h exp=1/0000000100000002", a_rd_valid, a_rd_data); end
    a_wr_data = 32'd19;
    step();
    a_wr_valid = 0;
    tests++; if (a_wr_overflow !== 1'b1 || a_count !== 5'd16) begin fails++; $display("FAIL full_ovf_pulse got=%b/%0d exp=1/16", a_wr_overflow, a_count); end
    step();
    tests++; if (a_wr_overflow !== 1'b0) begin fails++; $display("FAIL full_ovf_clear got=%b exp=0", a_wr_overflow); end
    a_rd_ready = 1; a_wr_valid = 1; a_wr_data = 32'd20;
    step();
    tests++; if (a_count !== 5'd14 || a_wr_overflow !== 1'b1) begin fails++; $display("FAIL full_pushpop got=%0d/%b exp=14/1", a_count, a_wr_overflow); end
    tests++; if (a_rd_data !== 64'h00000003_00000004) begin fails++; $display("FAIL full_beat1 got=%h exp=0000000300000004", a_rd_data); end
    a_rd_ready = 0; a_wr_data = 32'd21;
    step();
    a_wr_valid = 0;
    tests++; if (a_count !== 5'd15 || a_wr_overflow !== 1'b0) begin fails++; $display("FAIL full_accept got=%0d/%b exp=15/0", a_count, a_wr_overflow); end
  endtask

  task automatic test_drain();
    do_reset();
    a_rd_ready = 1; a_wr_valid = 1; a_wr_data = 32'hA1;
    step();
    a_wr_data = 32'hA2;
    step();
    a_wr_data = 32'hA3;
    step();
    a_wr_valid = 0;
    tests++; if (a_rd_valid !== 1'b1 || a_rd_data !== 64'h000000A1_000000A2) begin fails++; $display("FAIL drain_full_beat got=%b/%h exp=1/000000a1000000a2", a_rd_valid, a_rd_data); end
    tests++; if (a_count !== 5'd1) begin fails++; $display("FAIL drain_count_pre got=%0d exp=1", a_count); end
    a_drain = 1;
    step();
    tests++; if (a_rd_valid !== 1'b1 || a_rd_data !== 64'h000000A3_00000000) begin fails++; $display("FAIL drain_partial got=%b/%h exp=1/000000a300000000", a_rd_valid, a_rd_data); end
    tests++; if (a_count !== 5'd0 || a_empty !== 1'b1) begin fails++; $display("FAIL drain_count got=%0d/%b exp=0/1", a_count, a_empty); end
    step();
    tests++; if (a_rd_valid !== 1'b0 || a_rd_data !== 64'h000000A3_00000000) begin fails++; $display("FAIL drain_drop got=%b/%h exp=0/000000a300000000", a_rd_valid, a_rd_data); end
    a_drain = 0;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      a_wr_valid = 1; a_wr_data = 32'(32'h100 + i);
      step();
    end
    tests++; if (a_count !== 5'd7 || a_rd_valid !== 1'b1) begin fails++; $display("FAIL flush_pre got=%0d/%b exp=7/1", a_count, a_rd_valid); end
    a_flush = 1; a_wr_data = 32'hAA; a_rd_ready = 1;
    step();
    a_flush = 0; a_wr_data = 32'h55;
    tests++; if (a_count !== 5'd0 || a_empty !== 1'b1) begin fails++; $display("FAIL flush_count got=%0d/%b exp=0/1", a_count, a_empty); end
    tests++; if (a_rd_valid !== 1'b0 || a_rd_data !== 64'h0 || a_wr_overflow !== 1'b0) begin fails++; $display("FAIL flush_out got=%b/%h/%b exp=0/0/0", a_rd_valid, a_rd_data, a_wr_overflow); end
    step();
    a_wr_data = 32'h66;
    step();
    a_wr_valid = 0;
    tests++; if (a_rd_valid !== 1'b0) begin fails++; $display("FAIL flush_cold_c2 got=%b exp=0", a_rd_valid); end
    step();
    tests++; if (a_rd_valid !== 1'b1 || a_rd_data !== 64'h00000055_00000066) begin fails++; $display("FAIL flush_cold_beat got=%b/%h exp=1/0000005500000066", a_rd_valid, a_rd_data); end
    step();
    tests++; if (a_count !== 5'd0 || a_rd_valid !== 1'b0) begin fails++; $display("FAIL flush_discard got=%0d/%b exp=0/0", a_count, a_rd_valid); end
  endtask

  task automatic test_almost_full();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      a_wr_valid = 1; a_wr_data = 32'(i);
      step();
    end
    tests++; if (a_count !== 5'd11 || a_almost_full !== 1'b0) begin fails++; $display("FAIL af_below got=%0d/%b exp=11/0", a_count, a_almost_full); end
    a_wr_data = 32'd13;
    step();
    a_wr_valid = 0;
    tests++; if (a_count !== 5'd12 || a_almost_full !== 1'b1) begin fails++; $display("FAIL af_set got=%0d/%b exp=12/1", a_count, a_almost_full); end
    a_rd_ready = 1;
    step();
    a_rd_ready = 0;
    tests++; if (a_count !== 5'd10 || a_almost_full !== 1'b0) begin fails++; $display("FAIL af_clear got=%0d/%b exp=10/0", a_count, a_almost_full); end
  endtask

  task automatic test_wrap();
    logic [31:0]  q [$];
    logic [127:0] exp_beat;
    int sent = 0;
    int beats = 0;
    int cyc = 0;
    int max_cnt = 0;
    do_reset();
    // A one-word drained beat shifts rd_ptr to 1 so later beats straddle index 15 -> 0.
    b_drain = 1; b_wr_valid = 1; b_wr_data = 32'hCAFE0000;
    step();
    b_wr_valid = 0;
    step();
    tests++; if (b_rd_valid !== 1'b1 || b_rd_data !== {32'hCAFE0000, 96'h0}) begin fails++; $display("FAIL wrap_offset got=%b/%h exp=1/cafe0000 followed by zeros", b_rd_valid, b_rd_data); end
    b_drain = 0; b_rd_ready = 1;
    step();
    while (beats < 25 && cyc < 3000) begin
      b_wr_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
      b_wr_data  = 32'(32'h1000 + sent);
      b_rd_ready = ($urandom_range(0, 2) != 0);
      if (int'(b_count) > max_cnt) max_cnt = int'(b_count);
      if (b_wr_valid && b_wr_ready) begin
        q.push_back(b_wr_data);
        sent++;
      end
      if (b_rd_valid && b_rd_ready) begin
        tests++;
        if (q.size() < 4) begin
          fails++; $display("FAIL wrap_underrun got=beat exp=fewer than 4 words queued (%0d)", q.size());
        end else begin
          exp_beat = {q[0], q[1], q[2], q[3]};
          for (int k = 0; k < 4; k++) void'(q.pop_front());
          if (b_rd_data !== exp_beat) begin fails++; $display("FAIL wrap_beat%0d got=%h exp=%h", beats, b_rd_data, exp_beat); end
        end
        beats++;
      end
      step();
      cyc++;
    end
    b_wr_valid = 0; b_rd_ready = 0;
    tests++; if (beats != 25) begin fails++; $display("FAIL wrap_timeout got=%0d beats exp=25", beats); end
    tests++; if (max_cnt > 16) begin fails++; $display("FAIL wrap_max_count got=%0d exp<=16", max_cnt); end
    tests++; if (q.size() != 0 || b_count !== 5'd0) begin fails++; $display("FAIL wrap_leftover got=%0d/%0d exp=0/0", q.size(), b_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_drain();
    test_flush();
    test_almost_full();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operand_stream_fifo.md
# operand_stream_fifo

Parametrised operand staging FIFO between the host-side loader and the systolic array edge. Accepts one DATA_W word per cycle under a valid/ready handshake and emits PACK-word beats to the array through a registered show-ahead output stage. It supports back-pressure on both sides, simultaneous push and pop, a programmable almost-full threshold, a synchronous flush, and a drain mode that emits a zero-padded partial beat.

## Interface
- DATA_W, 32, width of one operand word
- DEPTH, 16384, storage words; power of two, ≥ 2*PACK
- PACK, 2, words per output beat; power of two, 1..8
- AF_LEVEL, DEPTH-64, almost_full asserts when count ≥ AF_LEVEL
- CNT_W, $clog2(DEPTH)+1, width of count

- clk  in  1  rising-edge clock; the block has one clock domain
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous clear of pointers, count and output stage
- drain  in  1  level; allows emission of a partial beat
- wr_data  in  DATA_W  push word
- wr_valid  in  1  push request
- wr_ready  out  1  storage can accept a word (count < DEPTH)
- wr_overflow  out  1  one-cycle pulse: wr_valid while !wr_ready
- rd_data  out  DATA_W*PACK  beat; oldest word in the MSB slice, newest in the LSB slice
- rd_valid  out  1  rd_data holds a beat
- rd_ready  in  1  consumer takes the beat
- count  out  CNT_W  words in storage, excluding the output stage
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AF_LEVEL

## Operation
- Push: wr_valid && wr_ready writes mem[wr_ptr] and increments wr_ptr modulo DEPTH.
- Output stage load condition (ld): (!rd_valid || rd_ready) && (count ≥ PACK, or drain && count ≥ 1).
- Full load: rd_data = {mem[rd_ptr], …, mem[rd_ptr+PACK-1]}. Indices wrap modulo DEPTH. rd_ptr advances by PACK.
- Partial load: occurs only when drain=1 and count < PACK. Words occupy the top slices in age order, and the remaining lower slices are 0. rd_ptr advances by count.
- Pop without reload: rd_valid && rd_ready && !ld clears rd_valid. rd_data holds its last value.
- Count update: count_next = count + push − taken. taken is PACK, the partial amount, or 0. Push and load in the same cycle are both applied, with no loss and no double count.
- Same-cycle bypass is not allowed: wr_ready and the ld test use the registered count. A word pushed in cycle N is not loaded before edge N+1.
- Precedence: reset > flush > normal operation.
- Flush: wr_ptr, rd_ptr and count are set to 0, and rd_valid is set to 0. A write or pop in the same cycle is discarded, and wr_overflow is 0. Memory contents are left untouched.
- Pushes while full are dropped and wr_overflow pulses. State is unchanged.
- Reset values: rd_data 0, rd_valid 0, count 0, empty 1, full 0, almost_full 0, wr_ready 1, wr_overflow 0.

## Timing
- empty, full, almost_full and wr_ready are decoded combinationally from the registered count. They reflect an event one cycle after its clock edge.
- wr_overflow is registered and goes high the cycle after the dropped push.
- Latency:
  - Enough words are present at edge E (count ≥ PACK after E), the output stage is free, and flush is low: rd_valid rises after edge E+1.
  - First-beat minimum, PACK=2, pushes in cycles 0 and 1: rd_valid=1 in cycle 3.
- Sustained throughput: one beat per cycle while rd_ready=1 and count ≥ PACK. Push rate caps this at 1 word per cycle.
- rd_data and rd_valid are stable while rd_valid && !rd_ready.
- Reset or flush asserted mid-stream: outputs take reset values after that edge. The first push after release behaves as from cold start.

## Test plan
- Reset release, PACK=2: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with rd_ready=1 -> beats 0x00000011_00000022 then 0x00000033_00000044, first rd_valid in cycle 3, then empty=1.
- DEPTH=16: fill 16 words with rd_ready=0 -> full=1, wr_ready=0, count=16. Push a 17th word -> wr_overflow pulses for one cycle and count stays 16. Push and pop in the same cycle -> count stays consistent (16−2+0, then accepts).
- Wrap-around, DEPTH=16, PACK=4: stream 100 words with random wr_valid/rd_ready -> output order matches a model, beats straddling index 15→0 are correct, and count never exceeds 16.
- Push 3 words with PACK=2, then raise drain -> one full beat, then beat {w3, 0}. count=0, rd_valid drops after rd_ready.
- Flush while count=7 and rd_valid=1, with a simultaneous push -> next cycle count=0, empty=1, rd_valid=0, and the push is discarded. A fresh push→beat sequence matches the cold-start latency.
- almost_full with AF_LEVEL=12, DEPTH=16: push 11 words -> 0. Push the 12th -> almost_full=1 the following cycle. One pop -> almost_full clears.
